// File: rtl/cp_sched_pkg.sv
// cp_sched_pkg: guard-ratio codes, guard-length helper and scheduler state set
package cp_sched_pkg;

    localparam logic [1:0] G_1_4  = 2'd0;
    localparam logic [1:0] G_1_8  = 2'd1;
    localparam logic [1:0] G_1_16 = 2'd2;
    localparam logic [1:0] G_1_32 = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REL} state_t;

    function automatic int clogb2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int tg_len(input int n, input logic [1:0] g);
        return g == G_1_4  ? n >> 2 :
               g == G_1_8  ? n >> 3 :
               g == G_1_16 ? n >> 4 : n >> 5;
    endfunction

endpackage

// File: rtl/cp_skid.sv
// cp_skid: two-entry valid/ready buffer; out_data is always the head entry
module cp_skid #(
    parameter int w = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [w-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [w-1:0] out_data,
    output logic [1:0]   count
);

    logic [w-1:0] q1;
    logic         pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = count != 2'd0;

    // head/second-entry update; the head only changes when empty or popped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= 2'd0;
            out_data <= '0;
            q1       <= '0;
        end else begin
            if (count == 2'd0 || (count == 2'd1 && pop)) begin
                if (in_valid) out_data <= in_data;
            end else if (pop) begin
                out_data <= q1;
            end
            if (in_valid && ((count == 2'd1 && !pop) || (count == 2'd2 && pop)))
                q1 <= in_data;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/cp_sched.sv
// cp_sched: reads a resident OFDM symbol with its cyclic prefix and streams it out
module cp_sched
    import cp_sched_pkg::*;
#(
    parameter int num_sz = 16,
    parameter int fft_n  = 256,
    parameter int aw     = clogb2(fft_n)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [1:0]          param_g,
    input  logic                sym_valid,
    output logic                sym_done,
    output logic                rd_en,
    output logic [aw-1:0]       rd_addr,
    input  logic [2*num_sz-1:0] rd_data,
    output logic [2*num_sz-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_first,
    output logic                out_last
);

    localparam int cw = aw + 1;
    localparam int dw = 2 * num_sz;
    localparam int sw = dw + 2;

    state_t        state;
    logic [1:0]    g;
    logic [1:0]    pend_g;
    logic          pend;
    logic [cw-1:0] remaining;
    logic [cw-1:0] tg;
    logic          first_pend;
    logic          rd_v;
    logic          rd_first;
    logic          rd_last;
    logic [sw-1:0] skid_q;
    logic [1:0]    skid_cnt;
    logic          pop;

    assign tg        = cw'(tg_len(fft_n, g));
    assign pop       = out_valid & out_ready;
    // a slot freed by this cycle's transfer may be reused, keeping the stream gap-free
    assign rd_en     = (state == RUN) && ((int'(skid_cnt) + int'(rd_v) - int'(pop)) < 2);
    assign out_data  = skid_q[dw-1:0];
    assign out_last  = skid_q[dw];
    assign out_first = skid_q[dw+1];

    // symbol scheduler: guard capture, address/count sequencing and release handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            g          <= G_1_4;
            pend       <= 1'b0;
            pend_g     <= G_1_4;
            rd_addr    <= '0;
            remaining  <= '0;
            first_pend <= 1'b0;
            sym_done   <= 1'b0;
        end else begin
            sym_done <= 1'b0;
            if (load && state != IDLE) begin
                pend   <= 1'b1;
                pend_g <= param_g;
            end
            unique case (state)
                IDLE: begin
                    if (load) g <= param_g;
                    if (sym_valid) begin
                        state      <= RUN;
                        rd_addr    <= aw'(fft_n) - aw'(tg);
                        remaining  <= cw'(fft_n) + tg;
                        first_pend <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        rd_addr    <= rd_addr + aw'(1);
                        remaining  <= remaining - cw'(1);
                        first_pend <= 1'b0;
                        if (remaining == cw'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state    <= REL;
                        sym_done <= 1'b1;
                    end
                end
                REL: begin
                    state <= IDLE;
                    pend  <= 1'b0;
                    if (load) g <= param_g;
                    else if (pend) g <= pend_g;
                end
            endcase
        end
    end

    // read-in-flight tracking; flags ride alongside the returning sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v     <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_v     <= rd_en;
            rd_first <= first_pend;
            rd_last  <= remaining == cw'(1);
        end
    end

    cp_skid #(.w(sw)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_v),
        .in_data  ({rd_first, rd_last, rd_data}),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (skid_q),
        .count    (skid_cnt)
    );

endmodule

// File: tb/tb_cp_sched.sv
// tb_cp_sched: scoreboard bench for cp_sched with a queue-based prefix model
module tb_cp_sched;

    localparam int FFT = 256;
    localparam int NS  = 16;
    localparam int AW  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            load = 1'b0;
    logic [1:0]      param_g = 2'd0;
    logic            sym_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic            sym_done, rd_en, out_valid, out_first, out_last;
    logic [AW-1:0]   rd_addr;
    logic [2*NS-1:0] rd_data, out_data;

    cp_sched #(.num_sz(NS), .fft_n(FFT)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .param_g  (param_g),
        .sym_valid(sym_valid),
        .sym_done (sym_done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_first(out_first),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    logic [33:0] exp_q[$];
    int          addr_q[$];
    logic [31:0] mem[16][FFT];
    int          tests = 0, fails = 0, cyc = 0, done_cnt = 0, samp_cnt = 0;
    int          exp_first_cyc = -1, sym_idx = 0, issued = 0, xfer = 0;
    bit          rnd_ready = 0, hold_v = 0;
    logic [33:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected stream of one symbol: tail of length fft_n/(4*2^g) then the whole symbol
    task automatic push_sym(input int s, input int gg);
        int tg = FFT / (4 * (1 << gg));
        int n  = FFT + tg;
        for (int i = 0; i < n; i++) begin
            int a = (FFT - tg + i) % FFT;
            exp_q.push_back({i == 0, i == n - 1, mem[s % 16][a]});
            addr_q.push_back(a);
        end
    endtask

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // symbol buffer: one-cycle read latency, plus read-order and occupancy checks
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            issued = 0;
            xfer = 0;
        end else begin
            if (rd_en) begin
                issued++;
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_read: got addr %0d expected no read", rd_addr);
                end else check("rd_addr", 64'(rd_addr), 64'(addr_q.pop_front()));
                rd_data <= mem[sym_idx % 16][rd_addr];
            end
            if (out_valid && out_ready) xfer++;
            check("outstanding_le2", 64'((issued - xfer) <= 2), 64'd1);
        end
    end

    // output monitor: pops the scoreboard on every transfer
    always @(negedge clk) begin
        if (!reset) begin
            if (sym_done) begin
                done_cnt++;
                if (sym_valid) exp_first_cyc = cyc + 4;
            end
            if (hold_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_stable", 64'({out_first, out_last, out_data}), 64'(held));
                hold_v = 0;
            end
            if (out_valid) begin
                if (out_first && exp_first_cyc >= 0) begin
                    check("first_latency", 64'(cyc), 64'(exp_first_cyc));
                    exp_first_cyc = -1;
                end
                if (out_ready) begin
                    samp_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_sample: got %0h expected nothing", out_data);
                    end else check("sample", 64'({out_first, out_last, out_data}), 64'(exp_q.pop_front()));
                end else begin
                    hold_v = 1;
                    held = {out_first, out_last, out_data};
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_sym_done", 64'(sym_done), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_first", 64'(out_first), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
    endtask

    task automatic do_load(input int v);
        @(posedge clk);
        #1 load = 1'b1;
        param_g = 2'(v);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic start_sym(input int gg);
        @(posedge clk);
        #1 sym_idx++;
        samp_cnt = 0;
        push_sym(sym_idx, gg);
        exp_first_cyc = cyc + 3;
        sym_valid = 1'b1;
        @(posedge clk);
        #1 sym_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 5000) begin
            @(negedge clk);
            if (sym_done) break;
            n++;
        end
        if (n == 5000) begin
            tests++;
            fails++;
            $display("FAIL sym_done_timeout: got no sym_done expected one within 5000 cycles");
        end
    endtask

    initial begin
        int n;
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < FFT; a++) mem[s][a] = $urandom;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        reset = 1'b0;

        // default guard 1/4
        start_sym(0);
        wait_done();

        // guard 1/32, with a load of 1/8 arriving mid-symbol
        do_load(3);
        start_sym(3);
        repeat (50) @(posedge clk);
        #1 load = 1'b1;
        param_g = 2'd1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_done();
        start_sym(1);
        wait_done();

        // random backpressure
        do_load(0);
        rnd_ready = 1;
        start_sym(0);
        wait_done();
        start_sym(0);
        wait_done();
        rnd_ready = 0;

        // sym_valid held high across three symbols
        @(posedge clk);
        #1 sym_idx++;
        push_sym(sym_idx, 0);
        exp_first_cyc = cyc + 3;
        sym_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_done();
            sym_idx++;
            push_sym(sym_idx, 0);
        end
        repeat (2) @(posedge clk);
        #1 sym_valid = 1'b0;
        wait_done();

        // reset in the middle of a 1/16 symbol
        do_load(2);
        start_sym(2);
        n = 0;
        while (samp_cnt < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_sample_100", 64'(samp_cnt >= 100), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        exp_q.delete();
        addr_q.delete();
        hold_v = 0;
        exp_first_cyc = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // guard must be back to 1/4 after reset
        start_sym(0);
        wait_done();
        repeat (5) @(posedge clk);

        check("sym_done_count", 64'(done_cnt), 64'd9);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("addr_q_empty", 64'(addr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule
